// File: rtl/x25519_mult_arbiter.sv
// Round-robin arbiter that shares one non-pipelined X25519 field multiplier between NUM_PORTS requesters.
// Optional BUSY watchdog is built when X25519_MULT_ARB_TIMEOUT_EN is defined.
module x25519_mult_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DRAIN_CYCLES   = 1200,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PORTS-1:0]     req_valid,
  input  logic [NUM_PORTS*264-1:0] req_a,
  input  logic [NUM_PORTS*264-1:0] req_b,
  output logic [NUM_PORTS-1:0]     req_ready,
  output logic [NUM_PORTS-1:0]     resp_valid,
  output logic                     resp_err,
  output logic [263:0]             resp_out,
  output logic                     mult_en,
  output logic [263:0]             mult_a,
  output logic [263:0]             mult_b,
  input  logic                     mult_out_valid,
  input  logic [263:0]             mult_out
);
  localparam int W   = 264;
  localparam int GW  = $clog2(NUM_PORTS);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

  state_t               r_state;
  logic [DCW-1:0]       r_drain_cnt;
  logic [GW-1:0]        r_last_grant;
  logic [GW-1:0]        r_owner;
  logic [NUM_PORTS-1:0] r_req_ready;
  logic [NUM_PORTS-1:0] r_resp_valid;
  logic                 r_mult_en;
  logic [W-1:0]         r_hold_a;
  logic [W-1:0]         r_hold_b;
  logic [W-1:0]         r_resp_out;

  logic                 w_grant_found;
  logic [GW-1:0]        w_grant_idx;
  logic [GW-1:0]        w_cand;
  logic [W-1:0]         w_req_a [NUM_PORTS];
  logic [W-1:0]         w_req_b [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign w_req_a[i] = req_a[i*W +: W];
    assign w_req_b[i] = req_b[i*W +: W];
  end

`ifdef X25519_MULT_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] r_busy_cnt;
  logic           r_timed_out;
  logic           r_resp_err;
  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    // Walk from lowest to highest priority so the port nearest after last_grant wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_cand = GW'((32'(r_last_grant) + 32'(k)) % NUM_PORTS);
      if (req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_DRAIN;
      r_drain_cnt  <= DCW'(DRAIN_CYCLES);
      r_last_grant <= GW'(NUM_PORTS - 1);
      r_owner      <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_mult_en    <= 1'b0;
      r_hold_a     <= '0;
      r_hold_b     <= '0;
      r_resp_out   <= '0;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
      r_busy_cnt   <= '0;
      r_timed_out  <= 1'b0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_mult_en    <= 1'b0;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
      r_resp_err   <= 1'b0;
`endif
      case (r_state)
        // The multiplier has no reset; anything it emits here belongs to a pre-reset operation.
        S_DRAIN: begin
          if (r_drain_cnt == '0) r_state <= S_IDLE;
          else                   r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        S_IDLE: begin
          if (w_grant_found) begin
            r_hold_a    <= w_req_a[w_grant_idx];
            r_hold_b    <= w_req_b[w_grant_idx];
            r_req_ready <= NUM_PORTS'(1) << w_grant_idx;
            r_owner     <= w_grant_idx;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mult_en <= 1'b1;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
          r_busy_cnt <= '0;
`endif
          r_state   <= S_BUSY;
        end
        S_BUSY: begin
          if (mult_out_valid) begin
            r_resp_out <= mult_out;
            r_state    <= S_RESP;
          end
`ifdef X25519_MULT_ARB_TIMEOUT_EN
          else if (r_busy_cnt == TCW'(TIMEOUT_CYCLES)) begin
            r_resp_out  <= '0;
            r_timed_out <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_resp_valid <= NUM_PORTS'(1) << r_owner;
          r_last_grant <= r_owner;
          r_state      <= S_IDLE;
`ifdef X25519_MULT_ARB_TIMEOUT_EN
          r_resp_err <= r_timed_out;
          if (r_timed_out) begin
            // A late product from the abandoned multiply must be swallowed.
            r_timed_out <= 1'b0;
            r_drain_cnt <= DCW'(DRAIN_CYCLES);
            r_state     <= S_DRAIN;
          end
`endif
        end
        default: r_state <= S_DRAIN;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_out   = r_resp_out;
  assign mult_en    = r_mult_en;
  assign mult_a     = r_hold_a;
  assign mult_b     = r_hold_b;
endmodule

// File: doc/x25519_mult_arbiter.md
# x25519_mult_arbiter

Round-robin arbiter that shares one non-pipelined X25519 field multiplier between `NUM_PORTS` requesters (ladder step units, inversion engine). Captures the granted requester's operands into holding registers and keeps them stable for the whole multiply. Issues a single-cycle start and routes the reduced 264-bit product back to the owning port. Sits between the requesters and the multiplier instance in the X25519 core.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `DRAIN_CYCLES`, 1200: cycles after reset during which multiplier output is ignored. Must be at least the worst-case multiply latency.
- `TIMEOUT_CYCLES`, 4095: watchdog limit per multiply. Used only when the timeout feature is compiled in.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_PORTS: per-port request.
- `req_a`, in, NUM_PORTS*264: operand A. Port i occupies bits [i*264 +: 264].
- `req_b`, in, NUM_PORTS*264: operand B, same packing as `req_a`.
- `req_ready`, out, NUM_PORTS: one-cycle pulse when the port's operands are captured.
- `resp_valid`, out, NUM_PORTS: one-cycle pulse to the owning port when its result is ready.
- `resp_err`, out, 1: qualifies `resp_valid`; 1 means the multiply timed out.
- `resp_out`, out, 264: result, shared by all ports. Meaningful only while a `resp_valid` bit is set.
- `mult_en`, out, 1: start pulse to the multiplier.
- `mult_a`, out, 264: operand A to the multiplier, driven from the holding register.
- `mult_b`, out, 264: operand B to the multiplier, driven from the holding register.
- `mult_out_valid`, in, 1: multiplier done.
- `mult_out`, in, 264: multiplier result.

## Operation
State machine: DRAIN → IDLE → ISSUE → BUSY → RESP → IDLE.

- **DRAIN** (entered on reset)
  - Down-counter loads `DRAIN_CYCLES`; `mult_out_valid` is ignored.
  - At 0 → IDLE.
  - Purpose: the multiplier has no reset, so a product still in flight across a reset must never be delivered.
- **IDLE**
  - Round-robin over `req_valid`, searching from port `(last_grant+1) mod NUM_PORTS`. `last_grant` resets to NUM_PORTS-1, so port 0 wins first.
  - On a grant: capture that port's `req_a`/`req_b` into the holding registers, pulse `req_ready[g]`, record owner `g`, → ISSUE.
- **ISSUE**
  - Assert `mult_en` for exactly one cycle, → BUSY.
- **BUSY**
  - Wait for `mult_out_valid`, then register `mult_out` into `resp_out`, → RESP.
  - A `mult_out_valid` seen in any state other than BUSY is ignored.
- **RESP**
  - Pulse `resp_valid[owner]` with `resp_err`=0, update `last_grant`=owner, → IDLE.

Rules:
- At most one `req_ready` bit and at most one `resp_valid` bit are set in any cycle.
- A requester holds `req_valid` and its operands until it sees `req_ready`. After `req_ready` it may change its operands freely.
- A requester must not reassert `req_valid` before its `resp_valid` arrives. The arbiter does not check this rule.
- `req_valid` dropping while not granted is legal and simply withdraws the request.
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_out`=0, `mult_en`=0, `mult_a`=0, `mult_b`=0, state=DRAIN.
- Asserting `rst_n` low mid-multiply clears everything immediately. No response is sent for the aborted request, and the requester must reissue it.

## Timing
- Grant latency from `req_valid` high in IDLE with no contention:
  - `req_ready` in the next cycle;
  - `mult_en` one cycle after that.
- Response: `resp_valid` rises 2 cycles after the `mult_out_valid` cycle (BUSY registers the result, then RESP drives the pulse).
- Throughput: one multiply per (multiplier latency + 4) cycles.
- Back-to-back use: the next grant can occur in the IDLE cycle immediately after RESP.
- Under full contention the ports are served 0,1,2,3,0,… with no starvation.

## Configuration
- `X25519_MULT_ARB_TIMEOUT_EN` defined:
  - A BUSY cycle counter starts at 0 on entry to BUSY.
  - If the counter reaches `TIMEOUT_CYCLES` with no `mult_out_valid`, `resp_out`=0 and the block → RESP with `resp_err`=1.
  - It then → DRAIN, so a late product is discarded, before returning to IDLE.
- Not defined:
  - No counter is built, and BUSY waits indefinitely.
  - `resp_err` is tied to 0.

## Test plan
- Reset, hold `mult_out_valid` high for 10 cycles during DRAIN → no `resp_valid`. Then request port 2 → `req_ready`=0b0100 within 1 cycle after DRAIN ends.
- Port 1 requests a=9, b=9. The multiplier model takes 1000 cycles and returns 81 → `mult_en` is a single pulse, `mult_a`/`mult_b` stay at 9 throughout, and `resp_valid`=0b0010 with `resp_out`=81.
- All 4 ports request continuously → grant order 0,1,2,3,0,1. Each `resp_valid` bit matches the preceding grant.
- Port 0 changes `req_a` the cycle after `req_ready` → `mult_a` stays unchanged until `resp_valid`.
- With the timeout macro defined and `TIMEOUT_CYCLES`=50, the model never responds → `resp_valid`=owner with `resp_err`=1 at BUSY+50. A late `mult_out_valid` is then ignored.
- `rst_n` asserted mid-BUSY → all outputs read 0 and no response is sent. After DRAIN, a new request completes normally.
